ahb_bus_arbiter: RTL and testbench

Shares one AHB bus between `NUM_MASTERS` master-interface instances. It takes each master's `hbusreq_in`/`hlock` and returns a one-hot `hgrant`. It also produces the registered `hmaster` index and the `hmastlock` flag that steer the address/write-data muxes. It sits between the master interfaces and the shared address/control/wdata mux, alongside the slave decoder.

---
 rtl/ahb_arb_pkg.sv | 21 ++
 rtl/ahb_bus_arbiter_if.sv | 28 ++
 rtl/ahb_arb_pick.sv | 36 +++
 rtl/ahb_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 126 ++++++++++++
 5 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB bus arbiter: HTRANS encodings,
// arbiter state enum and the index-width helper.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        OWN    = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

    // Index width: max(1, clog2(n)).
    function automatic int unsigned mw_of(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration bundle between the master interfaces and the AHB bus arbiter.
interface ahb_bus_arbiter_if
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3
) ();
    localparam int unsigned MW = mw_of(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic                   hready;
    logic [1:0]             htrans;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MW-1:0]          hmaster;
    logic                   hmastlock;

    // Requesting side: masters plus the slave-mux ready/trans feedback.
    modport master (
        output hbusreq, hlock, hready, htrans,
        input  hgrant, hmaster, hmastlock
    );

    // Arbiter side.
    modport slave (
        input  hbusreq, hlock, hready, htrans,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_arb_pick.sv
// Combinational rotating picker: first masked requester at or after start,
// wrapping at NUM_MASTERS-1 -> 0. Fixed priority uses start = 0.
module ahb_arb_pick
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned MW          = mw_of(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          start,
    input  logic [NUM_MASTERS-1:0] mask,
    output logic [NUM_MASTERS-1:0] win_oh,
    output logic [MW-1:0]          win_idx
);

    always_comb begin
        logic          found;
        int unsigned   j;
        logic [MW-1:0] jj;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            j  = (32'(start) + i) % NUM_MASTERS;
            jj = MW'(j);
            if (!found && req[jj] && mask[jj]) begin
                found       = 1'b1;
                win_oh[jj]  = 1'b1;
                win_idx     = jj;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: one-hot hgrant, registered hmaster/hmastlock, hold limit.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_HOLD       = 16
) (
    input logic              hclk,
    input logic              hreset,
    ahb_bus_arbiter_if.slave bus
);

    localparam int unsigned MW        = mw_of(NUM_MASTERS);
    localparam int unsigned HW        = mw_of(MAX_HOLD);
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [NUM_MASTERS-1:0] DEFAULT_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state;
    logic [NUM_MASTERS-1:0] grant;
    logic [MW-1:0]          owner;
    logic [MW-1:0]          master;
    logic                   mastlock;
    logic [HW-1:0]          hold_cnt;

    logic                   arb_c;
    logic                   any_req_c;
    logic                   owner_req_c;
    logic                   owner_lock_c;
    logic [NUM_MASTERS-1:0] others_c;
    logic                   hold_sat_c;
    logic                   hold_hit_c;
    logic [NUM_MASTERS-1:0] mask_c;
    logic [MW-1:0]          start_c;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [MW-1:0]          win_idx;
    logic                   win_lock_c;

`ifdef ARB_ROUND_ROBIN_EN
    logic [MW-1:0] ptr;
    assign start_c = (ptr == MW'(NUM_MASTERS - 1)) ? '0 : ptr + MW'(1);
`else
    assign start_c = '0;
`endif

    assign arb_c        = bus.hready && (bus.htrans != HTRANS_BUSY);
    assign any_req_c    = |bus.hbusreq;
    assign owner_req_c  = |(bus.hbusreq & grant);
    assign owner_lock_c = |(bus.hlock & grant);
    assign others_c     = bus.hbusreq & ~grant;
    assign hold_sat_c   = (hold_cnt == HW'(HOLD_LAST));
    assign hold_hit_c   = (MAX_HOLD != 0) && hold_sat_c;
    // Once others request, the owner is excluded so it cannot re-win.
    assign mask_c       = ((state != PARK) && (|others_c)) ? ~grant : '1;
    assign win_lock_c   = |(bus.hlock & win_oh);

    ahb_arb_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_pick (
        .req     (bus.hbusreq),
        .start   (start_c),
        .mask    (mask_c),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    // State, grant, hold counter and address-phase owner; hready=0 freezes all.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= PARK;
            grant    <= DEFAULT_OH;
            owner    <= MW'(DEFAULT_MASTER);
            master   <= MW'(DEFAULT_MASTER);
            mastlock <= 1'b0;
            hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr      <= MW'(DEFAULT_MASTER);
`endif
        end else if (bus.hready) begin
            master   <= owner;
            mastlock <= owner_lock_c;
            if (arb_c) begin
                case (state)
                    PARK: begin
                        if (any_req_c) begin
                            grant    <= win_oh;
                            owner    <= win_idx;
                            state    <= win_lock_c ? LOCKED : OWN;
                            hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                            ptr      <= win_idx;
`endif
                        end
                    end
                    default: begin
                        if (owner_lock_c) begin
                            state <= LOCKED;
                        end else if (!any_req_c) begin
                            grant    <= DEFAULT_OH;
                            owner    <= MW'(DEFAULT_MASTER);
                            state    <= PARK;
                            hold_cnt <= '0;
                        end else if (!owner_req_c || (hold_hit_c && (|others_c))) begin
                            grant    <= win_oh;
                            owner    <= win_idx;
                            state    <= win_lock_c ? LOCKED : OWN;
                            hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                            ptr      <= win_idx;
`endif
                        end else begin
                            state <= OWN;
                            if ((state == OWN) && !hold_sat_c) begin
                                hold_cnt <= hold_cnt + HW'(1);
                            end
                        end
                    end
                endcase
            end else if ((state == OWN) && !hold_sat_c) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    assign bus.hgrant    = grant;
    assign bus.hmaster   = master;
    assign bus.hmastlock = mastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter (3 masters, default 0, MAX_HOLD 4),
// scoreboard of expected grant/master/lock per clock step.
module tb_ahb_bus_arbiter;
    import ahb_arb_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [2:0] grant;
        logic [1:0] master;
        logic       lock;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    ahb_bus_arbiter_if #(.NUM_MASTERS(3)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS    (3),
        .DEFAULT_MASTER (0),
        .MAX_HOLD       (4)
    ) dut (
        .hclk   (clk),
        .hreset (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input string tag, input logic r, input logic [2:0] req,
                        input logic [2:0] lock, input logic rdy, input logic [1:0] tr,
                        input logic [2:0] eg, input logic [1:0] em, input logic el);
        exp_t e;
        rst         = r;
        bus.hbusreq = req;
        bus.hlock   = lock;
        bus.hready  = rdy;
        bus.htrans  = tr;
        sbq.push_back('{tag, eg, em, el});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({e.tag, " hgrant"},    32'(bus.hgrant),    32'(e.grant));
        check({e.tag, " hmaster"},   32'(bus.hmaster),   32'(e.master));
        check({e.tag, " hmastlock"}, 32'(bus.hmastlock), 32'(e.lock));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset, including a cycle with requests pending and hready low
        step("rst0", 1, 3'b000, 3'b000, 1, HTRANS_IDLE, 3'b001, 2'd0, 0);
        step("rst1", 1, 3'b110, 3'b000, 0, HTRANS_IDLE, 3'b001, 2'd0, 0);

        // Successive owner drops
        step("a1", 0, 3'b110, 3'b000, 1, HTRANS_NONSEQ, 3'b010, 2'd0, 0);
        step("a2", 0, 3'b100, 3'b000, 1, HTRANS_NONSEQ, 3'b100, 2'd1, 0);
        step("a3", 0, 3'b010, 3'b000, 1, HTRANS_NONSEQ, 3'b010, 2'd2, 0);
        step("a4", 0, 3'b110, 3'b000, 1, HTRANS_NONSEQ, 3'b010, 2'd1, 0);
        step("a5", 0, 3'b101, 3'b000, 1, HTRANS_NONSEQ, RR ? 3'b100 : 3'b001, 2'd1, 0);
        step("a6", 0, 3'b000, 3'b000, 1, HTRANS_NONSEQ, 3'b001, RR ? 2'd2 : 2'd0, 0);
        step("a7", 0, 3'b000, 3'b000, 1, HTRANS_IDLE,   3'b001, 2'd0, 0);

        // Hold limit forces handover to master 2
        step("b1", 0, 3'b010, 3'b000, 1, HTRANS_NONSEQ, 3'b010, 2'd0, 0);
        for (int i = 0; i < 3; i++)
            step("b_hold", 0, 3'b110, 3'b000, 1, HTRANS_SEQ, 3'b010, 2'd1, 0);
        step("b5", 0, 3'b110, 3'b000, 1, HTRANS_SEQ,    3'b100, 2'd1, 0);
        step("b6", 0, 3'b000, 3'b000, 1, HTRANS_IDLE,   3'b001, 2'd2, 0);
        step("b7", 0, 3'b000, 3'b000, 1, HTRANS_IDLE,   3'b001, 2'd0, 0);

        // Locked owner ignores the hold limit
        step("c1", 0, 3'b010, 3'b010, 1, HTRANS_NONSEQ, 3'b010, 2'd0, 0);
        for (int i = 0; i < 5; i++)
            step("c_lock", 0, 3'b110, 3'b010, 1, HTRANS_SEQ, 3'b010, 2'd1, 1);
        step("c7", 0, 3'b100, 3'b000, 1, HTRANS_NONSEQ, 3'b100, 2'd1, 0);
        step("c8", 0, 3'b000, 3'b000, 1, HTRANS_IDLE,   3'b001, 2'd2, 0);
        step("c9", 0, 3'b000, 3'b000, 1, HTRANS_IDLE,   3'b001, 2'd0, 0);

        // Wait states during handover
        step("d1", 0, 3'b010, 3'b000, 1, HTRANS_NONSEQ, 3'b010, 2'd0, 0);
        step("d2", 0, 3'b100, 3'b000, 1, HTRANS_NONSEQ, 3'b100, 2'd1, 0);
        for (int i = 0; i < 3; i++)
            step("d_wait", 0, 3'b100, 3'b000, 0, HTRANS_NONSEQ, 3'b100, 2'd1, 0);
        step("d6", 0, 3'b100, 3'b000, 1, HTRANS_NONSEQ, 3'b100, 2'd2, 0);

        // BUSY blocks re-arbitration
        for (int i = 0; i < 2; i++)
            step("e_busy", 0, 3'b010, 3'b000, 1, HTRANS_BUSY, 3'b100, 2'd2, 0);
        step("e3", 0, 3'b010, 3'b000, 1, HTRANS_SEQ,    3'b010, 2'd2, 0);
        step("e4", 0, 3'b010, 3'b000, 1, HTRANS_NONSEQ, 3'b010, 2'd1, 0);
        step("e5", 0, 3'b010, 3'b010, 1, HTRANS_NONSEQ, 3'b010, 2'd1, 1);

        // Reset mid-burst with hready low, then default master requesting
        step("f1", 1, 3'b110, 3'b010, 0, HTRANS_SEQ,    3'b001, 2'd0, 0);
        step("f2", 0, 3'b000, 3'b000, 1, HTRANS_IDLE,   3'b001, 2'd0, 0);
        step("f3", 0, 3'b001, 3'b000, 1, HTRANS_NONSEQ, 3'b001, 2'd0, 0);
        step("f4", 0, 3'b000, 3'b000, 1, HTRANS_IDLE,   3'b001, 2'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
